// File: rtl/psk_symbol_serializer_if.sv
// Sample-FIFO and serial-output signal bundle for psk_symbol_serializer.
// The slave modport is the serializer's view; master is the FIFO/driver side.
interface psk_symbol_serializer_if #(
    parameter int SAMPLE_WIDTH = 8,
    parameter int REPEAT_WIDTH = 8
);
    logic                    enable;
    logic [SAMPLE_WIDTH-1:0] sample;
    logic                    empty;
    logic [REPEAT_WIDTH-1:0] repeat_count;
    logic                    underrun_clr;
    logic                    read;
    logic                    pwm;
    logic                    symb_clk;
    logic                    busy;
    logic                    underrun;

    modport master (
        output enable, sample, empty, repeat_count, underrun_clr,
        input  read, pwm, symb_clk, busy, underrun
    );

    modport slave (
        input  enable, sample, empty, repeat_count, underrun_clr,
        output read, pwm, symb_clk, busy, underrun
    );
endinterface

// File: rtl/psk_symbol_serializer.sv
// Pulls samples from a FWFT FIFO and serialises BITS_PER_SYMBOL bits of each onto
// pwm, holding each bit CLKS_PER_BIT clocks and repeating the symbol per sample.
module psk_symbol_serializer #(
    parameter int SAMPLE_WIDTH    = 8,
    parameter int CLKS_PER_BIT    = 4,
    parameter int BITS_PER_SYMBOL = 4,
    parameter int REPEAT_WIDTH    = 8,
    parameter bit MSB_FIRST       = 1'b0,
    parameter bit IDLE_LEVEL      = 1'b0
) (
    input  logic                   clk,
    input  logic                   rst,
    psk_symbol_serializer_if.slave bus
);
    localparam int CLK_CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BIT_CNT_W = (BITS_PER_SYMBOL > 1) ? $clog2(BITS_PER_SYMBOL) : 1;
    localparam logic [CLK_CNT_W-1:0] CLK_LAST = CLK_CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_CNT_W-1:0] BIT_LAST = BIT_CNT_W'(BITS_PER_SYMBOL - 1);

    // A symbol must span at least two clocks so read has dropped before the next fetch.
    generate
        if (CLKS_PER_BIT < 1 || BITS_PER_SYMBOL < 1 || BITS_PER_SYMBOL > SAMPLE_WIDTH ||
            CLKS_PER_BIT * BITS_PER_SYMBOL < 2) begin : g_bad_params
            $error("psk_symbol_serializer: illegal CLKS_PER_BIT/BITS_PER_SYMBOL combination");
        end
    endgenerate

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t                  state_reg, state_next;
    logic [SAMPLE_WIDTH-1:0] sample_reg, sample_next;
    logic [SAMPLE_WIDTH-1:0] shift_reg, shift_next;
    logic [SAMPLE_WIDTH-1:0] shift_adv;
    logic [REPEAT_WIDTH-1:0] target_reg, target_next;
    logic [REPEAT_WIDTH-1:0] rep_cnt_reg, rep_cnt_next;
    logic [CLK_CNT_W-1:0]    clk_cnt_reg, clk_cnt_next;
    logic [BIT_CNT_W-1:0]    bit_cnt_reg, bit_cnt_next;
    logic                    read_reg, read_next;
    logic                    symb_clk_reg, symb_clk_next;
    logic                    underrun_reg, underrun_next;
    logic                    out_bit;
    logic                    clk_last;
    logic                    bit_last;
    logic                    rep_last;
    logic                    fetch;

    // Shift one position toward the output bit, zero filling from the far end.
    genvar gi;
    generate
        for (gi = 0; gi < SAMPLE_WIDTH; gi++) begin : g_shift
            if (MSB_FIRST) begin : g_msb
                if (gi == 0) begin : g_fill
                    assign shift_adv[gi] = 1'b0;
                end else begin : g_move
                    assign shift_adv[gi] = shift_reg[gi-1];
                end
            end else begin : g_lsb
                if (gi == SAMPLE_WIDTH - 1) begin : g_fill
                    assign shift_adv[gi] = 1'b0;
                end else begin : g_move
                    assign shift_adv[gi] = shift_reg[gi+1];
                end
            end
        end

        if (MSB_FIRST) begin : g_out_msb
            assign out_bit = shift_reg[SAMPLE_WIDTH-1];
        end else begin : g_out_lsb
            assign out_bit = shift_reg[0];
        end
    endgenerate

    assign clk_last = (clk_cnt_reg == CLK_LAST);
    assign bit_last = (bit_cnt_reg == BIT_LAST);
    assign rep_last = (rep_cnt_reg >= target_reg - REPEAT_WIDTH'(1));

    always_comb begin
        state_next    = state_reg;
        sample_next   = sample_reg;
        shift_next    = shift_reg;
        target_next   = target_reg;
        rep_cnt_next  = rep_cnt_reg;
        clk_cnt_next  = clk_cnt_reg;
        bit_cnt_next  = bit_cnt_reg;
        symb_clk_next = symb_clk_reg;
        underrun_next = underrun_reg;
        read_next     = 1'b0;
        fetch         = 1'b0;

        if (bus.enable) begin
            if (bus.underrun_clr) begin
                underrun_next = 1'b0;
            end

            case (state_reg)
                ST_IDLE: begin
                    fetch = ~bus.empty;
                end
                ST_RUN: begin
                    if (!clk_last) begin
                        clk_cnt_next = clk_cnt_reg + 1'b1;
                    end else if (!bit_last) begin
                        clk_cnt_next = '0;
                        bit_cnt_next = bit_cnt_reg + 1'b1;
                        shift_next   = shift_adv;
                    end else if (!rep_last) begin
                        clk_cnt_next = '0;
                        bit_cnt_next = '0;
                        rep_cnt_next = rep_cnt_reg + 1'b1;
                        shift_next   = sample_reg;
                    end else if (!bus.empty) begin
                        fetch = 1'b1;
                    end else begin
                        // Starved at a sample boundary: flag it and drop back to idle.
                        state_next    = ST_IDLE;
                        underrun_next = 1'b1;
                        clk_cnt_next  = '0;
                        bit_cnt_next  = '0;
                        rep_cnt_next  = '0;
                    end
                end
                default: begin
                    state_next = ST_IDLE;
                end
            endcase

            if (fetch) begin
                state_next    = ST_RUN;
                sample_next   = bus.sample;
                shift_next    = bus.sample;
                target_next   = (bus.repeat_count == '0) ? REPEAT_WIDTH'(1) : bus.repeat_count;
                rep_cnt_next  = '0;
                clk_cnt_next  = '0;
                bit_cnt_next  = '0;
                symb_clk_next = ~symb_clk_reg;
                read_next     = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= ST_IDLE;
            sample_reg   <= '0;
            shift_reg    <= '0;
            target_reg   <= '0;
            rep_cnt_reg  <= '0;
            clk_cnt_reg  <= '0;
            bit_cnt_reg  <= '0;
            read_reg     <= 1'b0;
            symb_clk_reg <= 1'b0;
            underrun_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            sample_reg   <= sample_next;
            shift_reg    <= shift_next;
            target_reg   <= target_next;
            rep_cnt_reg  <= rep_cnt_next;
            clk_cnt_reg  <= clk_cnt_next;
            bit_cnt_reg  <= bit_cnt_next;
            read_reg     <= read_next;
            symb_clk_reg <= symb_clk_next;
            underrun_reg <= underrun_next;
        end
    end

    assign bus.read     = read_reg;
    assign bus.pwm      = (state_reg == ST_RUN) ? out_bit : IDLE_LEVEL;
    assign bus.symb_clk = symb_clk_reg;
    assign bus.busy     = (state_reg == ST_RUN);
    assign bus.underrun = underrun_reg;

endmodule

// File: doc/psk_symbol_serializer.md
Name: psk_symbol_serializer

Overview:
Parametrised successor to the PSK symbol modulator. It pulls samples from a first-word-fall-through FIFO, serialises BITS_PER_SYMBOL bits of each sample onto a one-bit pwm line, holds each bit for CLKS_PER_BIT clocks, and repeats the symbol a runtime-programmable number of times. Additions over the previous generation:
- generic sample width
- selectable bit order
- defined idle level
- underrun detection with return to idle
- busy status
It sits between the sample FIFO and the output driver stage.

Parameters:
SAMPLE_WIDTH, 8, width of FIFO sample word
CLKS_PER_BIT, 4, clocks each bit is held on pwm (>=1)
BITS_PER_SYMBOL, 4, bits serialised per symbol (1..SAMPLE_WIDTH); CLKS_PER_BIT*BITS_PER_SYMBOL >= 2, elaboration error otherwise
REPEAT_WIDTH, 8, width of repeat_count
MSB_FIRST, 0, 0: serialise bit0 upward; 1: serialise bit SAMPLE_WIDTH-1 downward
IDLE_LEVEL, 0, pwm value while not running

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
enable  in  1  clock enable; 0 freezes all internal state
sample  in  SAMPLE_WIDTH  FIFO head word, valid while empty=0
empty  in  1  FIFO empty flag
repeat_count  in  REPEAT_WIDTH  symbol repetitions per sample; 0 treated as 1; latched at each fetch
underrun_clr  in  1  clears sticky underrun flag
read  out  1  registered one-cycle FIFO pop strobe
pwm  out  1  serial output
symb_clk  out  1  toggles on every sample fetch
busy  out  1  1 while in RUN
underrun  out  1  sticky: FIFO empty at a fetch point while running

Behaviour:
- Reset (rst=1 at clk edge, overrides enable, valid mid-operation):
  - state=IDLE; read=0; symb_clk=0; underrun=0; counters, shift and sample registers 0.
  - Outputs from the next cycle: pwm=IDLE_LEVEL, busy=0.
- read defaults to 0 every cycle. It is 1 only in the cycle after a fetch edge.
- A fetch at edge T means: sample captured into sample_reg and shift register; repeat target latched as max(repeat_count,1); bit/clk/rep counters zeroed; read=1 during cycle T+1; symb_clk toggles.
- enable=0: no state change, read=0, pwm holds its current value. Bit timing stretches by the disabled cycles.
- IDLE state: pwm=IDLE_LEVEL, busy=0. If enable=1 and empty=0, fetch and go to RUN.
- RUN state: busy=1. pwm = shift[0] (MSB_FIRST=0) or shift[SAMPLE_WIDTH-1] (MSB_FIRST=1).
  - First bit appears the cycle after the fetch edge.
  - clk_cnt increments each enabled cycle.
  - When clk_cnt=CLKS_PER_BIT-1: clk_cnt=0, bit_cnt+1, shift register shifts toward the output bit, zero fill.
- Symbol end (bit_cnt=BITS_PER_SYMBOL-1 and clk_cnt=CLKS_PER_BIT-1) takes priority over the plain shift:
  - If rep_cnt < target-1: rep_cnt+1, shift reloaded from sample_reg, bit_cnt=0.
  - Else if empty=0: fetch. Output stays gapless: the next sample's first bit follows the previous sample's last bit directly.
  - Else: underrun<=1, state=IDLE. pwm=IDLE_LEVEL from the next cycle. symb_clk unchanged.
- Symbol period is CLKS_PER_BIT*BITS_PER_SYMBOL cycles. Sample period is that times the target. Bits above BITS_PER_SYMBOL are never emitted.
- The parameter constraint guarantees read has deasserted before the next fetch decision, so no double pop.
- underrun is set only by the RUN-state symbol-end case. underrun_clr clears it. If set and clear occur in the same cycle, set wins. Underrun does not block a later restart from IDLE.
- Counter widths use $clog2 of their limits, minimum 1 bit. Counters never exceed their terminal values.

Test Plan:
1. Defaults, repeat_count=1, continuous FIFO of 0xC5 → pwm 1,0,1,0, each bit 4 cycles; read pulses once per 16 cycles; symb_clk toggles every 16 cycles; no idle gap between samples.
2. repeat_count=3 (then 0) with sample 0xC5 → same 16-cycle pattern emitted 3 times (48 cycles) per read; with repeat_count=0, one emission per read (16 cycles).
3. MSB_FIRST=1, sample 0xC5 → pwm 1,1,0,0 per symbol; MSB_FIRST=0 with 0xC5 gives 1,0,1,0.
4. Single sample, then empty held 1 → after 16 cycles: underrun=1, busy=0, pwm=IDLE_LEVEL, no extra read. Drive empty=0 → restart with read pulse while underrun stays 1. Assert underrun_clr with no new underrun → 0. Assert underrun_clr coincident with a new underrun → stays 1.
5. enable=0 for 5 cycles mid-bit → pwm frozen, no read, symb_clk unchanged; that sample's output lasts 21 cycles, with bit values and order unchanged.
6. rst asserted mid-symbol with FIFO non-empty → next cycle read=0, busy=0, pwm=IDLE_LEVEL, symb_clk=0, underrun=0; after rst release, fetch occurs on the first enabled edge.
